// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin encoding, coin unit values and
// the payout sequencer state set. Reused by the vending FSM and display logic.
package vending_pkg;

    localparam logic [1:0] COIN_100  = 2'b00;
    localparam logic [1:0] COIN_200  = 2'b01;
    localparam logic [1:0] COIN_500  = 2'b10;
    localparam logic [1:0] COIN_1000 = 2'b11;

    localparam int         NUM_COINS  = 4;
    localparam logic [3:0] MAX_AMOUNT = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REQ    = 3'd2,
        ST_FINISH = 3'd3,
        ST_ABORT  = 3'd4
    } disp_state_e;

    // Value of one coin of the given denomination, in 100-won units.
    function automatic logic [3:0] coin_value(input logic [1:0] sel);
        logic [3:0] val;
        case (sel)
            COIN_100:  val = 4'd1;
            COIN_200:  val = 4'd2;
            COIN_500:  val = 4'd5;
            COIN_1000: val = 4'd10;
            default:   val = 4'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_stock_bank.sv
// Per-denomination coin stock: four counters with a common reload and a
// one-hot decrement, plus a zero flag per counter.
module coin_stock_bank
    import vending_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int INIT_STOCK = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [NUM_COINS-1:0]           dec,
    output logic [NUM_COINS*CNT_W-1:0]     stock,
    output logic [NUM_COINS-1:0]           empty_flags
);

    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_STOCK);
    localparam logic [CNT_W-1:0] ZERO_VAL = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_VAL  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r [NUM_COINS];

    // Counter update: reset and reload restore full stock, otherwise a
    // requested decrement is taken only while the counter is non-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                cnt_r[i] <= INIT_VAL;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                cnt_r[i] <= INIT_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (dec[i] && (cnt_r[i] != ZERO_VAL)) begin
                    cnt_r[i] <= cnt_r[i] - ONE_VAL;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten the counters and derive the empty flags.
    always_comb begin
        stock       = {(NUM_COINS*CNT_W){1'b0}};
        empty_flags = 4'b0000;
        for (int i = 0; i < NUM_COINS; i++) begin
            stock[i*CNT_W +: CNT_W] = cnt_r[i];
            empty_flags[i]          = (cnt_r[i] == ZERO_VAL);
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Coin payout sequencer: pays a balance greedily, one coin per hopper
// handshake, and reports done / fail with the unpaid remainder.
module change_dispense_ctrl
    import vending_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int INIT_STOCK  = 20,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] amount,
    input  logic       refill,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] remaining,
    output logic [3:0] empty_flags
);

    // Last timeout-counter value before the wait is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    disp_state_e state_r, state_nxt_s;

    logic       coin_req_r, coin_req_nxt_s;
    logic [1:0] coin_sel_r, coin_sel_nxt_s;
    logic       busy_r;
    logic       done_r, done_nxt_s;
    logic       fail_r, fail_nxt_s;
    logic [3:0] remaining_r, remaining_nxt_s;
    logic [7:0] tmo_r, tmo_nxt_s;

    logic                       load_s;
    logic [NUM_COINS-1:0]       dec_s;
    logic [NUM_COINS*CNT_W-1:0] stock_s;
    logic [NUM_COINS-1:0]       empty_s;

    logic       pick_ok_s;
    logic [1:0] pick_sel_s;

    coin_stock_bank #(
        .CNT_W      (CNT_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk         (clk),
        .reset       (reset),
        .load        (load_s),
        .dec         (dec_s),
        .stock       (stock_s),
        .empty_flags (empty_s)
    );

    // Greedy pick: the largest denomination that fits the balance and is in
    // stock; later (larger) denominations override earlier ones.
    always_comb begin
        pick_ok_s  = 1'b0;
        pick_sel_s = COIN_100;
        for (int i = 0; i < NUM_COINS; i++) begin
            if ((coin_value(2'(i)) <= remaining_r) && !empty_s[i]) begin
                pick_ok_s  = 1'b1;
                pick_sel_s = 2'(i);
            end else begin
                pick_ok_s  = pick_ok_s;
                pick_sel_s = pick_sel_s;
            end
        end
    end

    // Next-state and next-output logic for the payout sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        coin_req_nxt_s  = 1'b0;
        coin_sel_nxt_s  = coin_sel_r;
        remaining_nxt_s = remaining_r;
        tmo_nxt_s       = tmo_r;
        done_nxt_s      = 1'b0;
        fail_nxt_s      = 1'b0;
        load_s          = 1'b0;
        dec_s           = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                load_s = refill;
                if (start) begin
                    remaining_nxt_s = amount;
                    if (amount <= MAX_AMOUNT) begin
                        state_nxt_s = ST_SELECT;
                    end else begin
                        state_nxt_s = ST_ABORT;
                        fail_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (remaining_r == 4'd0) begin
                    state_nxt_s = ST_FINISH;
                    done_nxt_s  = 1'b1;
                end else if (pick_ok_s) begin
                    state_nxt_s    = ST_REQ;
                    coin_sel_nxt_s = pick_sel_s;
                    coin_req_nxt_s = 1'b1;
                    tmo_nxt_s      = 8'd0;
                end else begin
                    // Nothing payable: remaining is left as the shortfall.
                    state_nxt_s = ST_ABORT;
                    fail_nxt_s  = 1'b1;
                end
            end
            ST_REQ: begin
                if (coin_ack) begin
                    state_nxt_s     = ST_SELECT;
                    remaining_nxt_s = remaining_r - coin_value(coin_sel_r);
                    dec_s           = 4'b0001 << coin_sel_r;
                end else if (tmo_r == TMO_LAST) begin
                    state_nxt_s = ST_ABORT;
                    fail_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s    = ST_REQ;
                    coin_req_nxt_s = 1'b1;
                    tmo_nxt_s      = tmo_r + 8'd1;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            ST_ABORT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            coin_req_r  <= 1'b0;
            coin_sel_r  <= COIN_100;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            remaining_r <= 4'd0;
            tmo_r       <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            coin_req_r  <= coin_req_nxt_s;
            coin_sel_r  <= coin_sel_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= done_nxt_s;
            fail_r      <= fail_nxt_s;
            remaining_r <= remaining_nxt_s;
            tmo_r       <= tmo_nxt_s;
        end
    end

    assign coin_req    = coin_req_r;
    assign coin_sel    = coin_sel_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fail        = fail_r;
    assign remaining   = remaining_r;
    assign empty_flags = empty_s;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: a transaction-level model plans
// each payout greedily and publishes the expected outputs cycle by cycle;
// a negedge process compares the DUT against them.
module tb_change_dispense_ctrl;

    localparam int TB_CNT_W = 8;
    localparam int TB_INIT  = 4;
    localparam int TB_TMO   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] amount = 4'd0;
    logic       refill = 1'b0;
    logic       coin_ack = 1'b0;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy, done, fail;
    logic [3:0] remaining;
    logic [3:0] empty_flags;

    change_dispense_ctrl #(
        .CNT_W       (TB_CNT_W),
        .INIT_STOCK  (TB_INIT),
        .ACK_TIMEOUT (TB_TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount      (amount),
        .refill      (refill),
        .coin_ack    (coin_ack),
        .coin_req    (coin_req),
        .coin_sel    (coin_sel),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .remaining   (remaining),
        .empty_flags (empty_flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int  coin_val [4] = '{1, 2, 5, 10};
    int  m_stock  [4];
    int  plan_q   [$];
    bit  check_en = 1'b0;
    bit  exp_req, exp_busy, exp_done, exp_fail;
    int  exp_sel, exp_rem;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_busy = 1'b0;
        exp_req  = 1'b0;
        exp_done = 1'b0;
        exp_fail = 1'b0;
    endtask

    task automatic check_stock(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_stock%0d", tag, i), int'(dut.stock_s[i*TB_CNT_W +: TB_CNT_W]), m_stock[i]);
        end
    endtask

    // Per-cycle comparison against the model expectations.
    always @(negedge clk) begin
        if (check_en) begin
            logic [3:0] e;
            for (int i = 0; i < 4; i++) e[i] = (m_stock[i] == 0);
            chk("coin_req", int'(coin_req), int'(exp_req));
            chk("busy", int'(busy), int'(exp_busy));
            chk("done", int'(done), int'(exp_done));
            chk("fail", int'(fail), int'(exp_fail));
            chk("remaining", int'(remaining), exp_rem);
            chk("empty_flags", int'(empty_flags), int'(e));
            if (exp_req) chk("coin_sel", int'(coin_sel), exp_sel);
        end
    end

    // One payout transaction: greedy plan from the model stock, then the
    // expected timeline (start->req 2, ack->req 2, last ack->done/fail 2).
    task automatic pay(input int amt, input int ack_dly, input bit never_ack, input bit do_refill);
        int rem;
        int r;
        int s [4];
        int found;
        start  = 1'b1;
        amount = 4'(amt);
        refill = do_refill;
        tick();
        start  = 1'b0;
        amount = 4'd0;
        refill = 1'b0;
        if (do_refill) for (int i = 0; i < 4; i++) m_stock[i] = TB_INIT;
        rem      = amt;
        exp_rem  = amt;
        exp_busy = 1'b1;
        exp_req  = 1'b0;
        exp_done = 1'b0;
        if (amt > 10) begin
            exp_fail = 1'b1;
            tick();
            set_idle();
            return;
        end
        exp_fail = 1'b0;
        plan_q.delete();
        s = m_stock;
        r = amt;
        while (r > 0) begin
            found = -1;
            for (int k = 3; k >= 0; k--)
                if (found < 0 && coin_val[k] <= r && s[k] > 0) found = k;
            if (found < 0) break;
            plan_q.push_back(found);
            s[found]--;
            r -= coin_val[found];
        end
        foreach (plan_q[n]) begin
            tick();
            exp_req = 1'b1;
            exp_sel = plan_q[n];
            if (never_ack) begin
                for (int j = 1; j < TB_TMO; j++) tick();
                tick();
                exp_req  = 1'b0;
                exp_fail = 1'b1;
                tick();
                set_idle();
                return;
            end
            for (int j = 0; j < ack_dly; j++) tick();
            coin_ack = 1'b1;
            tick();
            coin_ack = 1'b0;
            exp_req  = 1'b0;
            rem     -= coin_val[plan_q[n]];
            exp_rem  = rem;
            m_stock[plan_q[n]]--;
        end
        tick();
        if (rem == 0) exp_done = 1'b1;
        else          exp_fail = 1'b1;
        tick();
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_stock[i] = TB_INIT;
        set_idle();
        exp_rem = 0;
        exp_sel = 0;

        // Reset state
        tick();
        check_en = 1'b1;
        tick();
        chk("reset_coin_sel", int'(coin_sel), 0);
        check_stock("reset");
        reset = 1'b0;
        tick();

        // amount 9: 500, 200, 200
        pay(9, 1, 1'b0, 1'b0);
        chk("plan9_len", plan_q.size(), 3);
        chk("plan9_c0", plan_q[0], 2);
        chk("plan9_c1", plan_q[1], 1);
        chk("plan9_c2", plan_q[2], 1);
        chk("pay9_empty", int'(empty_flags), 0);
        chk("pay9_rem", int'(remaining), 0);
        check_stock("pay9");

        // amount 10: single 1000 coin, ack in the first request cycle
        pay(10, 0, 1'b0, 1'b0);
        chk("plan10_c0", plan_q[0], 3);
        chk("pay10_stock1000", int'(dut.stock_s[3*TB_CNT_W +: TB_CNT_W]), TB_INIT - 1);

        // Refill, drain 500, then amount 7 -> 200, 200, 200, 100
        refill = 1'b1;
        tick();
        refill = 1'b0;
        for (int i = 0; i < 4; i++) m_stock[i] = TB_INIT;
        tick();
        for (int k = 0; k < TB_INIT; k++) pay(5, 1, 1'b0, 1'b0);
        chk("drain500_empty", int'(empty_flags), 4'b0100);
        pay(7, 2, 1'b0, 1'b0);
        chk("plan7_len", plan_q.size(), 4);
        chk("plan7_c0", plan_q[0], 1);
        chk("plan7_c3", plan_q[3], 0);
        check_stock("pay7");

        // Coin_ack outside REQ must be ignored
        coin_ack = 1'b1;
        tick();
        tick();
        coin_ack = 1'b0;
        tick();

        // Refill, drain 100 and 200, then amount 1 is a shortfall
        refill = 1'b1;
        tick();
        refill = 1'b0;
        for (int i = 0; i < 4; i++) m_stock[i] = TB_INIT;
        for (int k = 0; k < TB_INIT; k++) pay(1, 1, 1'b0, 1'b0);
        for (int k = 0; k < TB_INIT; k++) pay(2, 1, 1'b0, 1'b0);
        chk("drain_empty", int'(empty_flags), 4'b0011);
        pay(1, 1, 1'b0, 1'b0);
        chk("short_plan_len", plan_q.size(), 0);
        chk("short_rem", int'(remaining), 1);

        // Start with refill in the same cycle, hopper never acks -> timeout
        pay(2, 0, 1'b1, 1'b1);
        chk("tmo_rem", int'(remaining), 2);
        chk("tmo_stock200", int'(dut.stock_s[1*TB_CNT_W +: TB_CNT_W]), TB_INIT);

        // Boundaries: amount 0 finishes, amount 11 aborts at once
        pay(0, 1, 1'b0, 1'b0);
        chk("zero_rem", int'(remaining), 0);
        pay(11, 1, 1'b0, 1'b0);
        chk("over_rem", int'(remaining), 11);
        tick();

        // Reset while a request is pending
        pay(5, 1, 1'b0, 1'b0);
        start  = 1'b1;
        amount = 4'd2;
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_rem  = 2;
        tick();
        exp_req = 1'b1;
        exp_sel = 1;
        start   = 1'b1;
        amount  = 4'd5;
        tick();
        start  = 1'b0;
        amount = 4'd0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        set_idle();
        exp_rem = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = TB_INIT;
        check_stock("midreq_reset");
        for (int k = 0; k < 3; k++) tick();

        check_en = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
